rv32_dmem_bridge: RTL
=====================

// Module: rv32_dmem_bridge
// PURPOSE
// - Downstream stage of the single-cycle RV32 core's data port; turns MemRead/MemWrite/address/wdata into one outstanding valid/ready bus txn.
// - Generates byte enables and store lane replication; sign/zero-extends loads.
// - Stalls the core (core_stall holds pc) until the response returns.
// - Flags misaligned, illegal-funct3, bus-error and timeout accesses on core_fault.
// PARAMETERS
// - TIMEOUT_CYCLES  256  max cycles in WAIT before forced fault; 0 disables the timeout
// PORTS
// - clk             in   1   clock, rising edge
// - reset_n         in   1   async active-low reset
// - core_addr       in   32  byte address (ALU result)
// - core_mem_read   in   1   load request
// - core_mem_write  in   1   store request
// - core_funct3     in   3   instr[14:12], access size/sign
// - core_wdata      in   32  store data (rs2)
// - core_rdata      out  32  formatted load data
// - core_stall      out  1   1 = core must hold pc/instruction
// - core_fault      out  1   1-cycle access fault pulse
// - bus_req_valid   out  1   request valid
// - bus_req_ready   in   1   request accepted
// - bus_req_addr    out  32  {core_addr[31:2],2'b00}
// - bus_req_we      out  1   1 = write
// - bus_req_be      out  4   byte enables
// - bus_req_wdata   out  32  lane-replicated store data
// - bus_rsp_valid   in   1   response valid
// - bus_rsp_rdata   in   32  raw word read data
// - bus_rsp_err     in   1   response error, qualified by bus_rsp_valid
// BEHAVIOUR
// - Reset: state IDLE; bus_req_valid=0, bus_req_* payload=0; captured rdata=0; fault flag=0; timeout counter=0.
// - Combinational outputs in reset: core_stall=0, core_rdata=0, core_fault=0.
// - access = core_mem_read|core_mem_write; both high => treated as write.
// - Legality:
//   - load funct3 000/001/010/100/101; store funct3 000/001/010; else illegal.
//   - Misaligned: half-word with addr[0]=1; word with addr[1:0]!=0.
//   - Illegal or misaligned => no bus txn, core_stall=0, core_fault=1 same cycle, core_rdata=0.
// - FSM IDLE -> REQ -> WAIT -> DONE -> IDLE:
//   - IDLE: legal access => core_stall=1; payload registered; next REQ.
//   - REQ: bus_req_valid=1, payload stable until bus_req_ready; bus_rsp_valid ignored. Handshake => WAIT, counter cleared.
//   - WAIT: counter increments each cycle.
//     - bus_rsp_valid => capture rdata and err; next DONE.
//     - counter==TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES!=0 => err forced; next DONE.
//   - DONE: core_stall=0; core_rdata=formatted captured word (0 if err); core_fault=err. Next IDLE; core advances pc at this edge.
// - core_stall = access & legal & (state!=DONE), combinational.
// - Minimum latency: req accepted in first REQ cycle, rsp next cycle => 4 cycles IDLE..DONE.
// - Store formatting (o = addr[1:0]):
//   - SB: be=4'b0001<<o, wdata={4{wdata[7:0]}}.
//   - SH: be=4'b0011<<o, wdata={2{wdata[15:0]}}.
//   - SW: be=4'b1111.
// - Loads: bus_req_be=4'b1111, bus_req_we=0.
//   - LB/LBU: select byte o, sign/zero extend to 32.
//   - LH/LHU: select half o[1], sign/zero extend to 32.
//   - LW: pass through.
// - Late rsp: bus_rsp_valid in IDLE/REQ/DONE is ignored, incl. a stale rsp after a timeout.
// - Reset mid-txn: return to IDLE immediately; bus_req_valid drops; abandoned rsp ignored.
// - core_addr/core_funct3/core_wdata stay stable while core_stall=1 (core holds instruction); bridge uses registered copies regardless.
// STRUCTURE
// - Package rv32_dmem_pkg: funct3 localparams (LB..LHU, SB..SW), FSM state encoding (2-bit), BE patterns.
// - Sub-module rv32_lsu_align (combinational): store BE/lane replication and load extract/extend; instantiated once.
// - Top module holds FSM, payload registers, timeout counter.
// - Core integration: core gains a stall input gating pc update and regfile write.
// TESTING
// - SW addr 0x100 wdata 0xDEADBEEF, ready=1, rsp next cycle -> be=1111, req_addr 0x100, stall 3 cycles, no fault.
// - SB addr 0x103 wdata 0x000000A5 -> be=1000, req_wdata=0xA5A5A5A5.
// - LB addr 0x102, rsp 0x12F03456 -> core_rdata=0xFFFFFFF0; LBU same -> 0x000000F0.
// - LH addr 0x101 -> no bus_req_valid, core_fault=1 same cycle, stall=0.
// - funct3=011 load -> same illegal response.
// - Ready held low 5 cycles -> payload stable; rsp_err=1 -> DONE with fault=1, rdata=0.
// - TIMEOUT_CYCLES=4, no rsp -> fault in DONE 4 cycles after handshake; stale rsp later ignored.
// - reset_n pulsed low in WAIT -> IDLE, valid=0, stall=0; next access completes normally.

Source files
------------

// File: rtl/rv32_dmem_pkg.sv
// rv32_dmem_pkg: funct3 codes, byte-enable patterns, FSM encoding and legality check for the data-memory bridge
package rv32_dmem_pkg;
  localparam logic [2:0] F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LBU = 3'b100, F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010;
  localparam logic [3:0] BE_B = 4'b0001, BE_H = 4'b0011, BE_W = 4'b1111;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  function automatic logic legal_access(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic ok_f3, mis;
    ok_f3 = we ? (f3 inside {F3_SB, F3_SH, F3_SW}) : (f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    mis = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    return ok_f3 && !mis;
  endfunction
endpackage

// File: rtl/rv32_lsu_align.sv
// rv32_lsu_align: store byte-enable/lane replication and load byte/half extraction with sign or zero extension
module rv32_lsu_align
  import rv32_dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_fmt
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    be = !we ? BE_W : funct3[1:0] == 2'b00 ? BE_B << off : funct3[1:0] == 2'b01 ? BE_H << off : BE_W;
    wdata_lane = !we ? '0 : funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    rdata_fmt = funct3[1:0] == 2'b00 ? {{24{b[7] & ~funct3[2]}}, b} :
                funct3[1:0] == 2'b01 ? {{16{h[15] & ~funct3[2]}}, h} : rdata;
  end
endmodule

// File: rtl/rv32_dmem_bridge.sv
// rv32_dmem_bridge: turns the core's load/store into one outstanding valid/ready bus transaction, stalling the core until done
module rv32_dmem_bridge
  import rv32_dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] core_addr,
  input  logic        core_mem_read,
  input  logic        core_mem_write,
  input  logic [2:0]  core_funct3,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        core_fault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_req_addr,
  output logic        bus_req_we,
  output logic [3:0]  bus_req_be,
  output logic [31:0] bus_req_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_err
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] f3_q, a_f3;
  logic [1:0] off_q, a_off;
  logic [31:0] rdata_q, al_wdata, al_rdata;
  logic [3:0] al_be;
  logic err_q, access, legal, timeout, a_idle, a_we;
  always_comb begin
    access = core_mem_read | core_mem_write;
    legal = legal_access(core_mem_write, core_funct3, core_addr[1:0]);
    timeout = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
    a_idle = state == IDLE;
    a_we = a_idle ? core_mem_write : bus_req_we;
    a_f3 = a_idle ? core_funct3 : f3_q;
    a_off = a_idle ? core_addr[1:0] : off_q;
  end
  rv32_lsu_align u_align (
    .we(a_we), .funct3(a_f3), .off(a_off), .wdata(core_wdata), .rdata(rdata_q),
    .be(al_be), .wdata_lane(al_wdata), .rdata_fmt(al_rdata)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = access && legal ? REQ : IDLE;
      REQ:     state_nx = bus_req_ready ? WAIT : REQ;
      WAIT:    state_nx = bus_rsp_valid || timeout ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus_req_valid = state == REQ;
    core_stall = reset_n && access && legal && state != DONE;
    core_fault = reset_n && (state == DONE ? err_q : a_idle && access && !legal);
    core_rdata = reset_n && state == DONE && !err_q ? al_rdata : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus_req_addr <= '0;
      bus_req_we <= 1'b0;
      bus_req_be <= '0;
      bus_req_wdata <= '0;
      f3_q <= '0;
      off_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      if (a_idle && access && legal) begin
        bus_req_addr <= {core_addr[31:2], 2'b00};
        bus_req_we <= core_mem_write;
        bus_req_be <= al_be;
        bus_req_wdata <= al_wdata;
        f3_q <= core_funct3;
        off_q <= core_addr[1:0];
      end
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (state == WAIT && (bus_rsp_valid || timeout)) begin
        err_q <= bus_rsp_valid ? bus_rsp_err : 1'b1;
        rdata_q <= bus_rsp_valid ? bus_rsp_rdata : rdata_q;
      end
    end
endmodule
